// File: rtl/iob_uart_rx_framer_pkg.sv
// Shared codes and types for the UART RX framer: control bytes, error codes, FSM states, FIFO entry.
// Enable payload escaping by defining IOB_UART_FRAMER_ESC_EN.
package iob_uart_rx_framer_pkg;

    localparam logic [7:0] STX      = 8'h02;
    localparam logic [7:0] ETX      = 8'h03;
    localparam logic [7:0] DLE      = 8'h10;
    localparam int         READ_GAP = 2;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_EMPTY   = 2'd1,
        ERR_OVERLEN = 2'd2,
        ERR_RESTART = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } entry_t;

endpackage

// File: rtl/iob_uart_rx_framer_if.sv
// Committed payload byte stream: valid/ready with a last-byte flag.
interface iob_uart_rx_framer_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/iob_uart_framer_fifo.sv
// Regfile FIFO with speculative write pointer: commit publishes, rollback discards uncommitted entries.
// Read side is combinational from committed entries only; full stalls the writer, never drops.
module iob_uart_framer_fifo
    import iob_uart_rx_framer_pkg::*;
#(
    parameter int DEPTH_W = 6
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   wr_en_i,
    input  entry_t wr_dat_i,
    input  logic   commit_i,
    input  logic   rollback_i,
    output logic   full_o,
    output logic   rd_vld_o,
    output entry_t rd_dat_o,
    input  logic   rd_rdy_i
);
    localparam int               DEPTH   = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0] PTR_ONE = 1;

    logic [DEPTH_W:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0] commit_ptr_q, commit_ptr_d;
    logic [DEPTH_W:0] rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [DEPTH];

    // Commit publishes the pointer after this cycle's write, so the closing byte is included.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (rollback_i) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (commit_i) begin
            commit_ptr_d = wr_ptr_d;
        end
        if (rd_vld_o && rd_rdy_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    assign full_o   = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                      (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
    assign rd_vld_o = (rd_ptr_q != commit_ptr_q);
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q[DEPTH_W-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[DEPTH_W-1:0]] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/iob_uart_rx_framer.sv
// STX..ETX frame extractor after uart_core RX; status pulses one cycle after the read, commit-only output stream.
// Reads stall on full FIFO; IOB_UART_FRAMER_ESC_EN enables DLE escaping inside payload.
module iob_uart_rx_framer
    import iob_uart_rx_framer_pkg::*;
#(
    parameter  int MAX_LEN = 64,
    parameter  int DEPTH_W = 6,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 rx_ready_i,
    input  logic [7:0]           rx_data_i,
    output logic                 rx_rd_o,
    iob_uart_rx_framer_if.master m,
    output logic                 frame_done_o,
    output logic [LEN_W-1:0]     frame_len_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);
    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE    = 1;
    localparam logic [1:0]       GAP_RELOAD = 2'(READ_GAP);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       hold_q, hold_d;
    logic [1:0]       gap_q, gap_d;
    logic             frame_done_q, frame_done_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             err_q, err_d;
    err_code_t        err_code_q, err_code_d;
    logic             lit;

    logic   fifo_wr, fifo_commit, fifo_rollback, fifo_full, fifo_rvld;
    entry_t fifo_wdat, fifo_rdat;

`ifdef IOB_UART_FRAMER_ESC_EN
    logic esc_q, esc_d;
    assign lit = esc_q;
`else
    assign lit = 1'b0;
`endif

    assign rx_rd_o = ~rst_i & en_i & rx_ready_i & (gap_q == 2'd0) & ~fifo_full;

    // The newest payload byte waits in hold_q so it can be written with last=1 once ETX arrives.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        hold_d        = hold_q;
        gap_d         = (gap_q != 2'd0) ? gap_q - 2'd1 : gap_q;
        frame_done_d  = 1'b0;
        frame_len_d   = frame_len_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        fifo_wr       = 1'b0;
        fifo_wdat     = '0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
`ifdef IOB_UART_FRAMER_ESC_EN
        esc_d         = esc_q;
`endif
        if (rx_rd_o) begin
            gap_d = GAP_RELOAD;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data_i == STX) begin
                        state_d = ST_PAYLOAD;
                        len_d   = '0;
                    end
                end
                ST_PAYLOAD: begin
`ifdef IOB_UART_FRAMER_ESC_EN
                    esc_d = 1'b0;
`endif
                    if (!lit && rx_data_i == ETX) begin
                        if (len_q == '0) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_EMPTY;
                        end else begin
                            fifo_wr      = 1'b1;
                            fifo_wdat    = {1'b1, hold_q};
                            fifo_commit  = 1'b1;
                            frame_done_d = 1'b1;
                            frame_len_d  = len_q;
                        end
                        len_d   = '0;
                        state_d = ST_IDLE;
                    end else if (!lit && rx_data_i == STX) begin
                        err_d         = 1'b1;
                        err_code_d    = ERR_RESTART;
                        fifo_rollback = 1'b1;
                        len_d         = '0;
                    end
`ifdef IOB_UART_FRAMER_ESC_EN
                    else if (!lit && rx_data_i == DLE) begin
                        esc_d = 1'b1;
                    end
`endif
                    else if (len_q == LEN_MAX) begin
                        err_d         = 1'b1;
                        err_code_d    = ERR_OVERLEN;
                        fifo_rollback = 1'b1;
                        len_d         = '0;
                        state_d       = ST_DISCARD;
                    end else begin
                        if (len_q != '0) begin
                            fifo_wr   = 1'b1;
                            fifo_wdat = {1'b0, hold_q};
                        end
                        hold_d = rx_data_i;
                        len_d  = len_q + LEN_ONE;
                    end
                end
                ST_DISCARD: begin
                    if (rx_data_i == ETX) begin
                        state_d = ST_IDLE;
                    end else if (rx_data_i == STX) begin
                        state_d = ST_PAYLOAD;
                        len_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            hold_q       <= '0;
            gap_q        <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
`ifdef IOB_UART_FRAMER_ESC_EN
            esc_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            gap_q        <= gap_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
`ifdef IOB_UART_FRAMER_ESC_EN
            esc_q        <= esc_d;
`endif
        end
    end

    iob_uart_framer_fifo #(.DEPTH_W(DEPTH_W)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (fifo_wr),
        .wr_dat_i   (fifo_wdat),
        .commit_i   (fifo_commit),
        .rollback_i (fifo_rollback),
        .full_o     (fifo_full),
        .rd_vld_o   (fifo_rvld),
        .rd_dat_o   (fifo_rdat),
        .rd_rdy_i   (m.m_ready)
    );

    assign m.m_valid    = fifo_rvld;
    assign m.m_data     = fifo_rdat.dat;
    assign m.m_last     = fifo_rdat.last;
    assign frame_done_o = frame_done_q;
    assign frame_len_o  = frame_len_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_iob_uart_rx_framer.sv
// Bench for iob_uart_rx_framer: queue-based frame parser as reference, scoreboard monitor on the stream and status pulses.
module tb_iob_uart_rx_framer;

    localparam int MAX_LEN = 4;
    localparam int DEPTH_W = 3;
    localparam int LEN_W   = 3;
`ifdef IOB_UART_FRAMER_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             rx_rd;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic             err;
    logic [1:0]       err_code;

    iob_uart_rx_framer_if m_if ();

    always #5 clk = ~clk;

    iob_uart_rx_framer #(.MAX_LEN(MAX_LEN), .DEPTH_W(DEPTH_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .rx_ready_i   (rx_ready),
        .rx_data_i    (rx_data),
        .rx_rd_o      (rx_rd),
        .m            (m_if),
        .frame_done_o (frame_done),
        .frame_len_o  (frame_len),
        .err_o        (err),
        .err_code_o   (err_code)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         rd_count = 0;
    logic [7:0] src_q[$];
    logic [8:0] exp_stream[$];
    int         exp_done[$];
    int         exp_err[$];

    // Reference parser state: payload collected so far for the open frame.
    bit         in_frame, discarding, esc_pend;
    logic [7:0] cur[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic void model_byte(input logic [7:0] b);
        logic lst;
        if (discarding) begin
            if (b == 8'h03) discarding = 1'b0;
            else if (b == 8'h02) begin
                discarding = 1'b0;
                in_frame   = 1'b1;
                cur.delete();
            end
        end else if (!in_frame) begin
            if (b == 8'h02) begin
                in_frame = 1'b1;
                cur.delete();
            end
        end else if (!esc_pend && b == 8'h03) begin
            if (cur.size() == 0) exp_err.push_back(1);
            else begin
                foreach (cur[i]) begin
                    lst = (i == cur.size() - 1);
                    exp_stream.push_back({lst, cur[i]});
                end
                exp_done.push_back(cur.size());
            end
            in_frame = 1'b0;
        end else if (!esc_pend && b == 8'h02) begin
            exp_err.push_back(3);
            cur.delete();
        end else if (!esc_pend && ESC_EN && b == 8'h10) begin
            esc_pend = 1'b1;
        end else begin
            esc_pend = 1'b0;
            if (cur.size() == MAX_LEN) begin
                exp_err.push_back(2);
                cur.delete();
                in_frame   = 1'b0;
                discarding = 1'b1;
            end else begin
                cur.push_back(b);
            end
        end
    endfunction

    task automatic send(input logic [7:0] b);
        src_q.push_back(b);
        model_byte(b);
    endtask

    task automatic send_bytes(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, {rx_rd, m_if.m_valid, m_if.m_data, m_if.m_last, frame_done, frame_len, err, err_code}, 0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        en = 1'b1;
        m_if.m_ready = 1'b1;
        while ((src_q.size() != 0 || exp_stream.size() != 0 || exp_done.size() != 0 ||
                exp_err.size() != 0) && t < 5000) begin
            tick();
            t++;
        end
        repeat (4) tick();
        if (t >= 5000)
            fail_now(name, $sformatf("timeout with %0d src / %0d stream bytes outstanding, expected 0",
                                     src_q.size(), exp_stream.size()));
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 8'h02;
        if (r < 4) return 8'h03;
        if (r == 4) return 8'h10;
        return 8'($urandom_range(0, 255));
    endfunction

    // uart_core stand-in: holds rx_ready until a read pulse consumes the byte.
    initial begin : driver
        bit rd_seen;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = rx_rd;
            @(posedge clk);
            #1;
            if (rd_seen && src_q.size() != 0) begin
                void'(src_q.pop_front());
                rx_ready = 1'b0;
            end
            if (!rx_ready && src_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                rx_ready = 1'b1;
                rx_data  = src_q[0];
            end
        end
    end

    initial begin : monitor
        bit prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
                continue;
            end
            if (rx_rd) begin
                rd_count++;
                check("rd_back_to_back", prev_rd, 0);
            end
            prev_rd = rx_rd;
            if (m_if.m_valid && m_if.m_ready) begin
                if (exp_stream.size() == 0)
                    fail_now("stream_extra", $sformatf("got byte %0h, expected none", m_if.m_data));
                else
                    check("stream", {m_if.m_last, m_if.m_data}, exp_stream.pop_front());
            end
            if (frame_done) begin
                if (exp_done.size() == 0)
                    fail_now("done_extra", $sformatf("got len %0d, expected no frame", frame_len));
                else
                    check("frame_len", frame_len, exp_done.pop_front());
            end
            if (err) begin
                if (exp_err.size() == 0)
                    fail_now("err_extra", $sformatf("got code %0d, expected no error", err_code));
                else
                    check("err_code", err_code, exp_err.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int t;
        rst = 1'b1;
        en  = 1'b1;
        m_if.m_ready = 1'b0;
        repeat (3) tick();
        check_idle("reset_state");
        rst = 1'b0;

        m_if.m_ready = 1'b1;
        send_bytes(128'h02_41_42_43_03, 5);
        send_bytes(128'h02_03, 2);
        send_bytes(128'h02_55_03, 3);
        send_bytes(128'h02_11_22_02_33_03, 6);
        send_bytes(128'h02_11_12_13_14_15_03, 7);
        send_bytes(128'h02_AA_03, 3);
        send_bytes(128'h02_10_03_41_03, 5);
        drain("directed");

        // Two 4-byte frames fill the 8-entry FIFO; the third frame's STX must wait.
        m_if.m_ready = 1'b0;
        base = rd_count;
        send_bytes(128'h02_21_22_23_24_03, 6);
        send_bytes(128'h02_31_32_33_34_03, 6);
        send_bytes(128'h02_41_42_43_44_03, 6);
        repeat (150) tick();
        check("full_stall_reads", rd_count - base, 12);
        check("full_stall_pending", src_q.size(), 6);
        drain("wrap");

        m_if.m_ready = 1'b0;
        send_bytes(128'h02_77_03_02_11, 5);
        t = 0;
        while (src_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        repeat (5) tick();
        check("committed_visible", m_if.m_valid, 1);
        rst = 1'b1;
        tick();
        check_idle("reset_mid_frame");
        rst = 1'b0;
        exp_stream.delete();
        exp_done.delete();
        exp_err.delete();
        cur.delete();
        in_frame   = 1'b0;
        discarding = 1'b0;
        esc_pend   = 1'b0;
        tick();
        check("post_reset_valid", m_if.m_valid, 0);
        m_if.m_ready = 1'b1;
        send_bytes(128'h02_66_03, 3);
        drain("after_reset");

        repeat (4000) begin
            tick();
            en           = ($urandom_range(0, 7) != 0);
            m_if.m_ready = ($urandom_range(0, 9) < 7);
            if (src_q.size() < 3) send(rand_byte());
        end
        drain("random");

        check("stream_leftover", exp_stream.size(), 0);
        check("done_leftover", exp_done.size(), 0);
        check("err_leftover", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
